// File: rtl/led_pwm_pkg.sv
// Shared state encoding, PWM constants and gamma helper for the LED PWM driver.
// The gamma helper is only referenced when LED_PWM_GAMMA_EN is defined.
package led_pwm_pkg;

   localparam int unsigned PWM_BITS   = 8;
   localparam int unsigned PWM_PERIOD = 256;

   typedef enum logic [1:0] {
      StOff   = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2
   } state_e;

   // Square-law brightness curve: upper byte of the 16-bit product d*d.
   function automatic logic [PWM_BITS-1:0] gamma(input logic [PWM_BITS-1:0] d);
      logic [2*PWM_BITS-1:0] p;
      p = {{PWM_BITS{1'b0}}, d} * {{PWM_BITS{1'b0}}, d};
      return p[2*PWM_BITS-1:PWM_BITS];
   endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler for the LED PWM driver: one tick every PRESCALE clk while run is high.
// Held at zero whenever run is low so every period starts from a clean phase.
module pwm_prescaler #(
   parameter int unsigned PRESCALE = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic tick
);

   localparam logic [15:0] Last = 16'(PRESCALE - 1);

   logic [15:0] pre_q, pre_d;

   assign tick = run && (pre_q == Last);

   always_comb begin
      pre_d = pre_q + 16'd1;
      if (!run || tick) begin
         pre_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

endmodule

// File: rtl/led_pwm_driver.sv
// Multi-channel LED PWM driver with period-aligned duty capture, phase stagger and drain-on-disable.
// Define LED_PWM_GAMMA_EN to apply a square-law gamma curve to the captured duty.
module led_pwm_driver
   import led_pwm_pkg::*;
#(
   parameter int unsigned PRESCALE   = 16,
   parameter int unsigned NUM_LEDS   = 8,
   parameter int unsigned PHASE_STEP = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [7:0]          duty_in,
   output logic [NUM_LEDS-1:0] led,
   output logic                period_start,
   output logic                busy
);

   state_e              state_q, state_d;
   logic [PWM_BITS-1:0] cnt_q, cnt_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [PWM_BITS-1:0] eff_duty;
   logic [NUM_LEDS-1:0] led_d;
   logic                run, tick, wrap, capture, led_on, ps_q;

   assign run          = (state_q != StOff);
   assign wrap         = tick && (cnt_q == '1);
   assign busy         = run;
   assign period_start = ps_q;

   pwm_prescaler #(
      .PRESCALE(PRESCALE)
   ) u_prescaler (
      .clk (clk),
      .rst (rst),
      .run (run),
      .tick(tick)
   );

   // A wrap with en high always restarts the period, even when leaving DRAIN.
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      unique case (state_q)
         StOff: begin
            if (en) begin
               state_d = StRun;
               capture = 1'b1;
            end
         end
         StRun: begin
            capture = wrap;
            if (!en) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (en) begin
               state_d = StRun;
               capture = wrap;
            end else if (wrap) begin
               state_d = StOff;
            end
         end
         default: state_d = StOff;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (!run) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   assign duty_d = capture ? duty_in : duty_q;

`ifdef LED_PWM_GAMMA_EN
   logic [PWM_BITS-1:0] eff_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         eff_q <= '0;
      end else if (capture) begin
         eff_q <= gamma(duty_in);
      end
   end

   assign eff_duty = eff_q;
`else
   assign eff_duty = duty_q;
`endif

   // Pins stay dark on entry to RUN and are forced dark on the edge that returns to OFF.
   assign led_on = run && (state_d != StOff);

   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
      localparam logic [PWM_BITS-1:0] Offset = PWM_BITS'((i * PHASE_STEP) % PWM_PERIOD);
      logic [PWM_BITS-1:0] phase;
      assign phase    = cnt_q + Offset;
      assign led_d[i] = led_on && (phase < eff_duty);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StOff;
         cnt_q   <= '0;
         duty_q  <= '0;
         led     <= '0;
         ps_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         duty_q  <= duty_d;
         led     <= led_d;
         ps_q    <= capture;
      end
   end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Self-checking bench for led_pwm_driver: table of duty vectors, hand-written corner sequences,
// and a randomized run compared cycle by cycle against a behavioural period/tick model.
`timescale 1ns/1ps
module tb_led_pwm_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic [7:0] duty_in = 8'd0;

   logic [7:0] led_a;
   logic       ps_a, busy_a;
   logic [1:0] led_b;
   logic       ps_b, busy_b;

   int n_cmp = 0;
   int n_err = 0;

`ifdef LED_PWM_GAMMA_EN
   localparam bit Gamma = 1'b1;
`else
   localparam bit Gamma = 1'b0;
`endif

   always #5 clk = ~clk;

   led_pwm_driver #(.PRESCALE(1), .NUM_LEDS(8), .PHASE_STEP(32)) dut_a (
      .clk(clk), .rst(rst), .en(en), .duty_in(duty_in),
      .led(led_a), .period_start(ps_a), .busy(busy_a)
   );

   led_pwm_driver #(.PRESCALE(3), .NUM_LEDS(2), .PHASE_STEP(100)) dut_b (
      .clk(clk), .rst(rst), .en(en), .duty_in(duty_in),
      .led(led_b), .period_start(ps_b), .busy(busy_b)
   );

   // ---------------- behavioural model ----------------
   // mode: 0 off, 1 running, 2 draining; t = clk index inside the 256*P clk period.
   typedef struct {
      int         mode;
      int         t;
      int         duty;
      logic [7:0] led;
      bit         ps;
   } mdl_t;

   function automatic int eff(input int d);
      if (Gamma) return (d * d) / 256;
      return d;
   endfunction

   function automatic mdl_t mdl_reset();
      mdl_t r;
      r.mode = 0; r.t = 0; r.duty = 0; r.led = '0; r.ps = 1'b0;
      return r;
   endfunction

   function automatic mdl_t mdl_step(input mdl_t m, input bit e, input int din,
                                     input int p, input int n, input int step);
      mdl_t       r;
      logic [7:0] on;
      r  = m;
      on = '0;
      if (m.mode == 0) begin
         r.led = '0;
         r.ps  = 1'b0;
         if (e) begin
            r.mode = 1; r.t = 0; r.duty = din; r.ps = 1'b1;
         end
         return r;
      end
      for (int i = 0; i < n; i++) on[i] = (((m.t / p) + i * step) % 256) < eff(m.duty);
      r.led  = on;
      r.ps   = 1'b0;
      r.mode = e ? 1 : 2;
      if (m.t == 256 * p - 1) begin
         r.t = 0;
         if (m.mode == 2 && !e) begin
            r.mode = 0;
            r.led  = '0;
         end else begin
            r.duty = din;
            r.ps   = 1'b1;
         end
      end else begin
         r.t = m.t + 1;
      end
      return r;
   endfunction

   mdl_t ma, mb;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ma <= mdl_reset();
         mb <= mdl_reset();
      end else begin
         ma <= mdl_step(ma, en, int'(duty_in), 1, 8, 32);
         mb <= mdl_step(mb, en, int'(duty_in), 3, 2, 100);
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         check("model_a", {22'd0, led_a, ps_a, busy_a}, {22'd0, ma.led, ma.ps, ma.mode != 0});
         check("model_b", {28'd0, led_b, ps_b, busy_b}, {28'd0, mb.led[1:0], mb.ps, mb.mode != 0});
      end
   end

   // ---------------- helpers ----------------
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      en  = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_ps(input int bound, output int cycles);
      cycles = 0;
      while (cycles < bound) begin
         @(negedge clk);
         cycles++;
         if (ps_a) return;
      end
      n_cmp++;
      n_err++;
      $display("FAIL wait_ps: got no period_start want one within %0d cycles", bound);
   endtask

   typedef struct {
      logic [7:0] duty;
      int         high_plain;
      int         high_gamma;
      int         maxon_plain;
      int         maxon_gamma;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int   c, psn, high, maxon, h1, h2;
      logic minbusy;

      vecs[0] = '{8'd0,   0,   0,   0, 0};
      vecs[1] = '{8'd1,   1,   0,   1, 0};
      vecs[2] = '{8'd32,  32,  4,   1, 1};
      vecs[3] = '{8'd64,  64,  16,  2, 1};
      vecs[4] = '{8'd128, 128, 64,  4, 2};
      vecs[5] = '{8'd200, 200, 156, 7, 5};
      vecs[6] = '{8'd255, 255, 254, 8, 8};

      // Reset state, then idle with en low.
      repeat (2) @(negedge clk);
      check("rst_led", {24'd0, led_a}, 32'd0);
      check("rst_ps", {31'd0, ps_a}, 32'd0);
      check("rst_busy", {31'd0, busy_a}, 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_busy", {31'd0, busy_a}, 32'd0);
      check("idle_led", {24'd0, led_a}, 32'd0);

      // One measured period per duty vector: channel 0 high count, one period_start, stagger.
      foreach (vecs[v]) begin
         do_reset();
         duty_in = vecs[v].duty;
         en      = 1'b1;
         wait_ps(600, c);
         high = 0; psn = 0; maxon = 0;
         for (int k = 1; k <= 256; k++) begin
            @(negedge clk);
            high += int'(led_a[0]);
            psn  += int'(ps_a);
            if ($countones(led_a) > maxon) maxon = $countones(led_a);
         end
         check("vec_high", high, Gamma ? vecs[v].high_gamma : vecs[v].high_plain);
         check("vec_period", psn, 1);
         check("vec_max_on", maxon, Gamma ? vecs[v].maxon_gamma : vecs[v].maxon_plain);
      end

      // Duty change mid-period only takes effect at the next capture.
      do_reset();
      duty_in = 8'd200;
      en      = 1'b1;
      wait_ps(600, c);
      h1 = 0; h2 = 0;
      for (int k = 1; k <= 512; k++) begin
         @(negedge clk);
         if (k <= 256) h1 += int'(led_a[0]);
         else h2 += int'(led_a[0]);
         if (k == 50) duty_in = 8'd10;
      end
      check("glitch_cur", h1, eff(200));
      check("glitch_next", h2, eff(10));

      // Drain: en drops at tick 100, driver runs to the wrap and then goes dark.
      do_reset();
      duty_in = 8'd64;
      en      = 1'b1;
      wait_ps(600, c);
      c = 0; psn = 0;
      while (c < 600) begin
         @(negedge clk);
         c++;
         if (c == 100) en = 1'b0;
         psn += int'(ps_a);
         if (!busy_a) break;
      end
      check("drain_len", c, 256);
      check("drain_ps", psn, 0);
      check("drain_led", {24'd0, led_a}, 32'd0);

      // Drop and re-raise before the wrap: period_start cadence is undisturbed.
      do_reset();
      en = 1'b1;
      wait_ps(600, c);
      c = 0; minbusy = 1'b1;
      while (c < 600) begin
         @(negedge clk);
         c++;
         if (c == 100) en = 1'b0;
         if (c == 200) en = 1'b1;
         minbusy &= busy_a;
         if (ps_a) break;
      end
      check("reraise_gap", c, 256);
      check("reraise_busy", {31'd0, minbusy}, 32'd1);

      // Asynchronous reset in the middle of an all-on window.
      do_reset();
      duty_in = 8'd255;
      en      = 1'b1;
      wait_ps(600, c);
      c = 0;
      while (c < 600 && led_a !== 8'hFF) begin
         @(negedge clk);
         c++;
      end
      check("arst_allones", {24'd0, led_a}, 32'hFF);
      #2 rst = 1'b1;
      #1;
      check("arst_led", {24'd0, led_a}, 32'd0);
      check("arst_ps", {31'd0, ps_a}, 32'd0);
      check("arst_busy", {30'd0, busy_a, busy_b}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("arst_ps_release", {31'd0, ps_a}, 32'd0);
      @(negedge clk);
      check("arst_ps_first", {31'd0, ps_a}, 32'd1);

      // Randomized duty every cycle with occasional enable toggles; model checks every cycle.
      do_reset();
      en = 1'b1;
      for (int k = 0; k < 20000; k++) begin
         @(negedge clk);
         duty_in = 8'($urandom);
         if ($urandom_range(0, 499) == 0) en = ~en;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
